// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit, active-low 7-segment display.
// Each digit slot has SETTLE_CYC blanked cycles while the external digit mux settles, then shows the digit.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int SETTLE_CYC   = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  blink_mask,
    input  logic [10:0] num,
    output logic [2:0]  light,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SHOW} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] slot_cnt;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [10:0]   code_q;
    logic          settle_end, slot_end, frame_end;

    assign settle_end = (slot_cnt == SW'(SETTLE_CYC - 1));
    assign slot_end   = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (light == 3'd7);

    function automatic logic [7:0] decode(input logic [10:0] code);
        case (code)
            11'd0:   decode = 8'hC0;
            11'd1:   decode = 8'hF9;
            11'd2:   decode = 8'hA4;
            11'd3:   decode = 8'hB0;
            11'd4:   decode = 8'h99;
            11'd5:   decode = 8'h92;
            11'd6:   decode = 8'h82;
            11'd7:   decode = 8'hF8;
            11'd8:   decode = 8'h80;
            11'd9:   decode = 8'h90;
            11'd11:  decode = 8'hBF;
            default: decode = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SETTLE;
            SETTLE:  if (!en) state_nxt = IDLE; else if (settle_end) state_nxt = SHOW;
            SHOW:    if (!en) state_nxt = IDLE; else if (slot_end) state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot/frame counters; blink_phase deliberately survives a disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            light       <= '0;
            code_q      <= '0;
        end else if (state == IDLE || !en) begin
            slot_cnt  <= '0;
            frame_cnt <= '0;
            light     <= '0;
        end else if (state == SETTLE) begin
            slot_cnt <= slot_cnt + 1'b1;
            if (settle_end) code_q <= num;
        end else if (slot_end) begin
            slot_cnt <= '0;
            light    <= light + 3'd1;
            if (light == 3'd7) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Outputs derive from registered state only, so reset blanks them asynchronously.
    always_comb begin
        an         = 8'hFF;
        seg        = 8'hFF;
        frame_done = 1'b0;
        if (state == SHOW) begin
            if (!(blink_mask[light] && blink_phase)) an = ~(8'b1 << light);
            seg        = decode(code_q);
            frame_done = en && frame_end;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short scan (8-cycle slots, 2-frame blink).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  blink_mask;
    logic [10:0] num;
    logic [2:0]  light;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;
    logic [10:0] num_tab [8];

    int checks   = 0;
    int failures = 0;

    display_scan_ctrl #(.SCAN_DIV(8), .SETTLE_CYC(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .blink_mask(blink_mask), .num(num),
        .light(light), .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always_comb num = num_tab[light];

    typedef struct {
        int          adv;
        bit          en;
        logic [7:0]  mask;
        logic [10:0] n2;
        logic [2:0]  light;
        logic [7:0]  an;
        logic [7:0]  seg;
        bit          sc;
        bit          fd;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] el, input logic [7:0] ea,
                       input logic [7:0] es, input bit sc, input bit ef);
        checks++;
        if (light !== el || an !== ea || (sc && seg !== es) || frame_done !== ef) begin
            failures++;
            $display("FAIL %s: got light=%0d an=%h seg=%h fd=%b, want light=%0d an=%h seg=%h(chk=%0b) fd=%b",
                     nm, light, an, seg, frame_done, el, ea, es, sc, ef);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) num_tab[k] = 11'(k);
        rst = 1'b1; en = 1'b0; blink_mask = 8'h00;

        // Cycle labels in the comments are edges counted from the first enabled edge.
        vecs.push_back('{1,  1'b1, 8'h00, 11'd2,    3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{2,  1'b1, 8'h00, 11'd2,    3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0});
        vecs.push_back('{5,  1'b1, 8'h00, 11'd2,    3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0}); // E7
        vecs.push_back('{1,  1'b1, 8'h00, 11'd2,    3'd1, 8'hFF, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{2,  1'b1, 8'h00, 11'd2,    3'd1, 8'hFD, 8'hF9, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd2, 8'hFB, 8'hA4, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd3, 8'hF7, 8'hB0, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd4, 8'hEF, 8'h99, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd5, 8'hDF, 8'h92, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd6, 8'hBF, 8'h82, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h00, 11'd2,    3'd7, 8'h7F, 8'hF8, 1'b1, 1'b0}); // E58
        vecs.push_back('{5,  1'b1, 8'h00, 11'd2,    3'd7, 8'h7F, 8'hF8, 1'b1, 1'b1}); // E63
        vecs.push_back('{1,  1'b1, 8'h00, 11'd2,    3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{2,  1'b1, 8'h03, 11'd2,    3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0}); // frame 1
        vecs.push_back('{8,  1'b1, 8'h03, 11'd2,    3'd1, 8'hFD, 8'hF9, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h03, 11'd2,    3'd2, 8'hFB, 8'hA4, 1'b1, 1'b0});
        vecs.push_back('{45, 1'b1, 8'h03, 11'd2,    3'd7, 8'h7F, 8'hF8, 1'b1, 1'b1}); // E127
        vecs.push_back('{3,  1'b1, 8'h03, 11'd2,    3'd0, 8'hFF, 8'hC0, 1'b1, 1'b0}); // frame 2 blanked
        vecs.push_back('{8,  1'b1, 8'h03, 11'd2,    3'd1, 8'hFF, 8'hF9, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h03, 11'd2,    3'd2, 8'hFB, 8'hA4, 1'b1, 1'b0});
        vecs.push_back('{48, 1'b1, 8'h03, 11'd2,    3'd0, 8'hFF, 8'hC0, 1'b1, 1'b0}); // frame 3
        vecs.push_back('{64, 1'b1, 8'h03, 11'd2,    3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0}); // frame 4 restored
        vecs.push_back('{8,  1'b1, 8'h03, 11'd2,    3'd1, 8'hFD, 8'hF9, 1'b1, 1'b0});
        vecs.push_back('{8,  1'b1, 8'h03, 11'd11,   3'd2, 8'hFB, 8'hBF, 1'b1, 1'b0}); // dash
        vecs.push_back('{64, 1'b1, 8'h03, 11'd12,   3'd2, 8'hFB, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{64, 1'b1, 8'h03, 11'd10,   3'd2, 8'hFB, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{64, 1'b1, 8'h03, 11'd2047, 3'd2, 8'hFB, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{64, 1'b1, 8'h03, 11'd2,    3'd2, 8'hFB, 8'hA4, 1'b1, 1'b0}); // E530

        step(2);
        chk("reset", 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        rst = 1'b0;
        step(2);
        chk("idle_hold", 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            en         = vecs[i].en;
            blink_mask = vecs[i].mask;
            num_tab[2] = vecs[i].n2;
            step(vecs[i].adv);
            chk($sformatf("vec%0d", i), vecs[i].light, vecs[i].an, vecs[i].seg, vecs[i].sc, vecs[i].fd);
        end

        // num changes mid-SHOW must not reach seg until the next latch point
        num_tab[2] = 11'd9;
        step(5);
        chk("num_mid_show", 3'd2, 8'hFB, 8'hA4, 1'b1, 1'b0);
        step(59);
        chk("num_next_slot", 3'd2, 8'hFB, 8'h90, 1'b1, 1'b0);
        num_tab[2] = 11'd2;

        // disable in the middle of slot 5, then restart from digit 0
        step(26);
        chk("slot5_show", 3'd5, 8'hDF, 8'h92, 1'b1, 1'b0);
        en = 1'b0;
        step(1);
        chk("en_drop", 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        step(3);
        chk("en_idle", 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        en = 1'b1;
        step(1);
        chk("reen_settle0", 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step(1);
        chk("reen_settle1", 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step(1);
        chk("reen_show", 3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0);

        // asynchronous reset between clock edges during SHOW
        step(24);
        chk("pre_rst_show", 3'd3, 8'hF7, 8'hB0, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst", 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        #2 rst = 1'b0;
        step(1);
        chk("post_rst_settle", 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step(2);
        chk("post_rst_show", 3'd0, 8'hFE, 8'hC0, 1'b1, 1'b0);
        step(8);
        chk("post_rst_slot1", 3'd1, 8'hFD, 8'hF9, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
